// File: rtl/jpeg_idct_x_sched.sv
// Row-pass scheduler: reads an 8x8 block as 16 half-rows and issues each row to the row IDCT as two paced beats.
// Define JPEG_IDCT_X_SCHED_STATS_EN to add the blocks_o / rows_o activity counters.
module jpeg_idct_x_sched #(
    parameter int ROW_CYCLES = 12,
    parameter int COEF_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              block_valid_i,
    output logic              block_ready_o,
    output logic              rd_en_o,
    output logic [3:0]        rd_addr_o,
    input  logic [COEF_W-1:0] rd_data0_i,
    input  logic [COEF_W-1:0] rd_data1_i,
    input  logic [COEF_W-1:0] rd_data2_i,
    input  logic [COEF_W-1:0] rd_data3_i,
    output logic              idct_valid_o,
    output logic [COEF_W-1:0] idct_data0_o,
    output logic [COEF_W-1:0] idct_data1_o,
    output logic [COEF_W-1:0] idct_data2_o,
    output logic [COEF_W-1:0] idct_data3_o,
    output logic [2:0]        idct_idx_o,
    output logic              busy_o,
    output logic              block_done_o
`ifdef JPEG_IDCT_X_SCHED_STATS_EN
    ,
    output logic [15:0]       blocks_o,
    output logic [19:0]       rows_o
`endif
);

    // A row needs at least RD0, RD1, BEAT, BEAT1 before the next one may start.
    localparam int RC = (ROW_CYCLES < 4) ? 4 : ROW_CYCLES;
    localparam int PW = $clog2(RC);
    localparam logic [PW-1:0] PACE_LOAD = PW'(RC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_BEAT,
        S_BEAT1,
        S_WAIT
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [2:0]         r_row;
    logic [PW-1:0]      r_pace;
    logic               r_done;
    logic [COEF_W-1:0]  r_data [4];
    logic [COEF_W-1:0]  w_rdData [4];
    logic               w_ready;
    logic               w_handshake;
    logic               w_rowEnd;
    logic               w_lastRow;

    assign w_rdData[0] = rd_data0_i;
    assign w_rdData[1] = rd_data1_i;
    assign w_rdData[2] = rd_data2_i;
    assign w_rdData[3] = rd_data3_i;

    assign w_ready     = (r_state == S_IDLE) && !flush_i;
    assign w_handshake = w_ready && block_valid_i;
    assign w_lastRow   = (r_row == 3'd7);
    // The pacing window closes one cycle before the counter would reach zero, so the next RD0 lands exactly RC cycles later.
    assign w_rowEnd    = ((r_state == S_BEAT1) || (r_state == S_WAIT)) && (r_pace == PW'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_handshake) w_nextState = S_RD0;
            S_RD0:   w_nextState = S_RD1;
            S_RD1:   w_nextState = S_BEAT;
            S_BEAT:  w_nextState = S_BEAT1;
            S_BEAT1, S_WAIT: begin
                if (w_rowEnd) w_nextState = w_lastRow ? S_IDLE : S_RD0;
                else          w_nextState = S_WAIT;
            end
            default: w_nextState = S_IDLE;
        endcase
        if (flush_i) w_nextState = S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_row  <= 3'd0;
            r_pace <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= !flush_i && w_rowEnd && w_lastRow;
            if (r_state == S_RD0)  r_pace <= PACE_LOAD;
            else if (r_pace != '0) r_pace <= r_pace - PW'(1);
            if (flush_i)           r_row <= 3'd0;
            else if (w_rowEnd)     r_row <= w_lastRow ? 3'd0 : r_row + 3'd1;
        end
    end

    // Half-0 returns during RD1 and half-1 during BEAT; each is held for its beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int j = 0; j < 4; j++) r_data[j] <= '0;
        end else if ((r_state == S_RD1) || (r_state == S_BEAT)) begin
            for (int j = 0; j < 4; j++) r_data[j] <= w_rdData[j];
        end
    end

    assign block_ready_o = w_ready;
    assign busy_o        = (r_state != S_IDLE);
    assign rd_en_o       = (r_state == S_RD0) || (r_state == S_RD1);
    assign rd_addr_o     = rd_en_o ? {r_row, (r_state == S_RD1)} : 4'd0;
    assign idct_valid_o  = (r_state == S_BEAT) || (r_state == S_BEAT1);
    assign idct_data0_o  = r_data[0];
    assign idct_data1_o  = r_data[1];
    assign idct_data2_o  = r_data[2];
    assign idct_data3_o  = r_data[3];
    assign idct_idx_o    = r_row;
    assign block_done_o  = r_done;

`ifdef JPEG_IDCT_X_SCHED_STATS_EN
    logic [15:0] r_blocks;
    logic [19:0] r_rows;

    // Counters survive flush on purpose; only reset clears them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_blocks <= 16'd0;
            r_rows   <= 20'd0;
        end else begin
            if (r_done)              r_blocks <= r_blocks + 16'd1;
            if (r_state == S_BEAT1)  r_rows   <= r_rows + 20'd1;
        end
    end

    assign blocks_o = r_blocks;
    assign rows_o   = r_rows;
`endif

endmodule

// File: tb/tb_jpeg_idct_x_sched.sv
// Bench for jpeg_idct_x_sched: a timeline model of the beat schedule checked every cycle, for ROW_CYCLES=12 and a clamped ROW_CYCLES=2.
module tb_jpeg_idct_x_sched;

    logic        clk;
    logic        rst_n;
    logic        flush [2];
    logic        bvalid [2];
    logic        ready [2];
    logic        rdEn [2];
    logic [3:0]  rdAddr [2];
    logic [15:0] rdData [2][4];
    logic        valid [2];
    logic [15:0] data [2][4];
    logic [2:0]  idx [2];
    logic        busy [2];
    logic        done [2];
`ifdef JPEG_IDCT_X_SCHED_STATS_EN
    logic [15:0] blocksO [2];
    logic [19:0] rowsO [2];
`endif

    logic [15:0] mem [16][4];
    int tests = 0;
    int failures = 0;

    int mCyc = 0;
    bit mActive [2] = '{0, 0};
    int mStart [2] = '{0, 0};
    int hsCyc [2] = '{0, 0};
    int hsCount [2] = '{0, 0};
    int dutDoneCyc [2] = '{0, 0};
    int dutDoneCount [2] = '{0, 0};
    int mBlocks [2] = '{0, 0};
    int mRows [2] = '{0, 0};

    jpeg_idct_x_sched #(.ROW_CYCLES(12), .COEF_W(16)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[0]), .block_valid_i(bvalid[0]),
        .block_ready_o(ready[0]), .rd_en_o(rdEn[0]), .rd_addr_o(rdAddr[0]),
        .rd_data0_i(rdData[0][0]), .rd_data1_i(rdData[0][1]),
        .rd_data2_i(rdData[0][2]), .rd_data3_i(rdData[0][3]),
        .idct_valid_o(valid[0]),
        .idct_data0_o(data[0][0]), .idct_data1_o(data[0][1]),
        .idct_data2_o(data[0][2]), .idct_data3_o(data[0][3]),
        .idct_idx_o(idx[0]), .busy_o(busy[0]), .block_done_o(done[0])
`ifdef JPEG_IDCT_X_SCHED_STATS_EN
        , .blocks_o(blocksO[0]), .rows_o(rowsO[0])
`endif
    );

    jpeg_idct_x_sched #(.ROW_CYCLES(2), .COEF_W(16)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[1]), .block_valid_i(bvalid[1]),
        .block_ready_o(ready[1]), .rd_en_o(rdEn[1]), .rd_addr_o(rdAddr[1]),
        .rd_data0_i(rdData[1][0]), .rd_data1_i(rdData[1][1]),
        .rd_data2_i(rdData[1][2]), .rd_data3_i(rdData[1][3]),
        .idct_valid_o(valid[1]),
        .idct_data0_o(data[1][0]), .idct_data1_o(data[1][1]),
        .idct_data2_o(data[1][2]), .idct_data3_o(data[1][3]),
        .idct_idx_o(idx[1]), .busy_o(busy[1]), .block_done_o(done[1])
`ifdef JPEG_IDCT_X_SCHED_STATS_EN
        , .blocks_o(blocksO[1]), .rows_o(rowsO[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Coefficient RAM with one cycle of read latency, one read port per scheduler.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (rdEn[i])
                for (int j = 0; j < 4; j++) rdData[i][j] <= mem[rdAddr[i]][j];
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, mCyc);
        end
    endtask

    // Timeline model: row r of a block handshaken at cycle h reads at h+1+r*R (+1) and beats two cycles later.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int R, k, ph, r;
            bit inBlock, eValid, eRd, eDone, eReady;
            R = (i == 0) ? 12 : 4;
            if (!rst_n) begin
                mActive[i] = 0;
                mBlocks[i] = 0;
                mRows[i] = 0;
            end else begin
                k = mCyc - mStart[i];
                inBlock = mActive[i] && k >= 1 && k <= 8 * R;
                ph = inBlock ? (k - 1) % R : 0;
                r = inBlock ? (k - 1) / R : 0;
                eValid = inBlock && ph >= 2 && ph <= 3;
                eRd = inBlock && ph <= 1;
                eDone = mActive[i] && k == 8 * R + 1;
                eReady = !inBlock && !flush[i];
                checkOutput($sformatf("busy%0d", i), int'(busy[i]), int'(inBlock));
                checkOutput($sformatf("ready%0d", i), int'(ready[i]), int'(eReady));
                checkOutput($sformatf("valid%0d", i), int'(valid[i]), int'(eValid));
                checkOutput($sformatf("done%0d", i), int'(done[i]), int'(eDone));
                checkOutput($sformatf("rdEn%0d", i), int'(rdEn[i]), int'(eRd));
                if (eRd) checkOutput($sformatf("rdAddr%0d", i), int'(rdAddr[i]), r * 2 + ph);
                if (eValid) begin
                    checkOutput($sformatf("idx%0d", i), int'(idx[i]), r);
                    for (int j = 0; j < 4; j++)
                        checkOutput($sformatf("data%0d_%0d", i, j), int'(data[i][j]),
                                    int'(mem[r * 2 + ph - 2][j]));
                end
`ifdef JPEG_IDCT_X_SCHED_STATS_EN
                checkOutput($sformatf("blocks%0d", i), int'(blocksO[i]), mBlocks[i] & 16'hFFFF);
                checkOutput($sformatf("rows%0d", i), int'(rowsO[i]), mRows[i] & 20'hFFFFF);
`endif
                if (done[i]) begin
                    dutDoneCyc[i] = mCyc;
                    dutDoneCount[i]++;
                end
                if (eDone) mBlocks[i]++;
                if (eValid && ph == 3) mRows[i]++;
                if (eReady && bvalid[i]) begin
                    mActive[i] = 1;
                    mStart[i] = mCyc;
                    hsCyc[i] = mCyc;
                    hsCount[i]++;
                end else if (flush[i] && inBlock) begin
                    mActive[i] = 0;
                end
            end
        end
        mCyc++;
    end

    // Returns just after the negedge of cycle c, while cycle c's outputs are still stable.
    task automatic atCycle(input int c);
        while (mCyc < c + 1) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic fillRam(input bit ramp);
        for (int n = 0; n < 16; n++)
            for (int j = 0; j < 4; j++)
                mem[n][j] = ramp ? 16'(4 * n + j) : 16'($urandom);
    endtask

    task automatic applyStimulus(input int i, output int h);
        int c0, n;
        c0 = hsCount[i];
        n = 0;
        @(posedge clk);
        #1 bvalid[i] = 1'b1;
        while (hsCount[i] == c0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput($sformatf("handshake%0d", i), hsCount[i] - c0, 1);
        h = hsCyc[i];
        @(posedge clk);
        #1 bvalid[i] = 1'b0;
    endtask

    task automatic waitDone(input int i, input int budget);
        int c0, n;
        c0 = dutDoneCount[i];
        n = 0;
        while (dutDoneCount[i] == c0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput($sformatf("doneSeen%0d", i), dutDoneCount[i] - c0, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int h, h1, d1, nhs;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            flush[i] = 1'b0;
            bvalid[i] = 1'b0;
        end
        fillRam(1'b1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (20) @(negedge clk);
        #1;
        checkOutput("idleReady", int'(ready[0]), 1);
        checkOutput("idleBusy", int'(busy[0]), 0);

        // Ramp-filled block: literal beat contents and spacing.
        applyStimulus(0, h);
        atCycle(h + 3);
        checkOutput("beat0Valid", int'(valid[0]), 1);
        checkOutput("beat0Idx", int'(idx[0]), 0);
        checkOutput("beat0D0", int'(data[0][0]), 0);
        checkOutput("beat0D3", int'(data[0][3]), 3);
        atCycle(h + 4);
        checkOutput("beat1D0", int'(data[0][0]), 4);
        atCycle(h + 15);
        checkOutput("row1Valid", int'(valid[0]), 1);
        checkOutput("row1Idx", int'(idx[0]), 1);
        checkOutput("row1D2", int'(data[0][2]), 10);
        waitDone(0, 200);
        checkOutput("latency12", dutDoneCyc[0] - h, 97);

        // Back-to-back blocks with valid held high.
        fillRam(1'b0);
        nhs = hsCount[0];
        @(posedge clk);
        #1 bvalid[0] = 1'b1;
        h1 = 0;
        for (int n = 0; n < 300 && hsCount[0] < nhs + 2; n++) begin
            @(negedge clk);
            #1;
            if (hsCount[0] == nhs + 1 && h1 == 0) h1 = hsCyc[0];
        end
        checkOutput("b2bHandshakes", hsCount[0] - nhs, 2);
        checkOutput("b2bGap", hsCyc[0] - h1, 97);
        @(posedge clk);
        #1 bvalid[0] = 1'b0;
        d1 = dutDoneCyc[0];
        waitDone(0, 200);
        checkOutput("b2bDoneSpacing", dutDoneCyc[0] - d1, 97);

        // Clamped instance: four-cycle rows.
        applyStimulus(1, h);
        atCycle(h + 3);
        checkOutput("clampBeat0", int'(valid[1]), 1);
        atCycle(h + 7);
        checkOutput("clampRow1Idx", int'(idx[1]), 1);
        checkOutput("clampRow1Valid", int'(valid[1]), 1);
        waitDone(1, 100);
        checkOutput("latency4", dutDoneCyc[1] - h, 33);

        // Flush during row 3's first beat.
        applyStimulus(0, h);
        atCycle(h + 38);
        @(posedge clk);
        #1 flush[0] = 1'b1;
        atCycle(h + 39);
        checkOutput("flushBeatValid", int'(valid[0]), 1);
        checkOutput("flushBeatIdx", int'(idx[0]), 3);
        @(posedge clk);
        #1 flush[0] = 1'b0;
        atCycle(h + 40);
        checkOutput("flushValid", int'(valid[0]), 0);
        checkOutput("flushReady", int'(ready[0]), 1);
        d1 = dutDoneCount[0];
        atCycle(h + 110);
        checkOutput("flushNoDone", dutDoneCount[0] - d1, 0);

        // Flush in idle blocks the handshake.
        nhs = hsCount[0];
        @(posedge clk);
        #1;
        flush[0] = 1'b1;
        bvalid[0] = 1'b1;
        @(negedge clk);
        #1 checkOutput("flushIdleReady", int'(ready[0]), 0);
        @(posedge clk);
        #1;
        flush[0] = 1'b0;
        bvalid[0] = 1'b0;
        checkOutput("flushIdleNoHs", hsCount[0] - nhs, 0);

        fillRam(1'b0);
        applyStimulus(0, h);
        atCycle(h + 3);
        checkOutput("restartIdx", int'(idx[0]), 0);
        checkOutput("restartD1", int'(data[0][1]), int'(mem[0][1]));

        // Asynchronous reset in row 5's wait window.
        atCycle(h + 65);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("rstReady", int'(ready[0]), 1);
        checkOutput("rstBusy", int'(busy[0]), 0);
        checkOutput("rstValid", int'(valid[0]), 0);
        checkOutput("rstRdEn", int'(rdEn[0]), 0);
        checkOutput("rstIdx", int'(idx[0]), 0);
        checkOutput("rstData", int'(data[0][0]), 0);
`ifdef JPEG_IDCT_X_SCHED_STATS_EN
        checkOutput("rstBlocks", int'(blocksO[0]), 0);
        checkOutput("rstRows", int'(rowsO[0]), 0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized blocks with occasional random flushes.
        for (int b = 0; b < 4; b++) begin
            fillRam(1'b0);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            applyStimulus(0, h);
            if ($urandom_range(0, 2) == 0) begin
                atCycle(h + int'($urandom_range(2, 95)));
                @(posedge clk);
                #1 flush[0] = 1'b1;
                @(posedge clk);
                #1 flush[0] = 1'b0;
            end
            atCycle(h + 99);
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
